// File: rtl/lsu_if.sv
// Data-bus channel between the load/store unit and memory: one request
// channel with a ready handshake plus a load response channel.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;

  modport master (
    output req_valid, we, addr, be, wdata,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, we, addr, be, wdata,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns one load or store request into a single data-bus
// transaction, stalling the pipeline until it completes.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  lsu_if.master       dbus
);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t      state, state_n;
  logic        legal, bad_align, access, launch;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [2:0]  mode_q;
  logic [1:0]  off_q;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Request decode; BU/HU are load-only, so a store with them is a no-op.
  always_comb begin
    access    = rd_en | wr_en;
    legal     = wr_en ? (mem_acc_mode <= MODE_W) : (mem_acc_mode <= MODE_HU);
    bad_align = (((mem_acc_mode == MODE_H) || (mem_acc_mode == MODE_HU)) && addr[0])
              || ((mem_acc_mode == MODE_W) && (addr[1:0] != 2'b00));
    misaligned = (state == IDLE) && access && legal && bad_align;
    launch     = (state == IDLE) && access && legal && !bad_align;
    stall      = launch || (state == REQ) || (state == WAIT_RSP);

    be_c    = '0;
    wdata_c = wdata;
    case (mem_acc_mode)
      MODE_B, MODE_BU: be_c = 4'b0001 << addr[1:0];
      MODE_H, MODE_HU: be_c = 4'b0011 << addr[1:0];
      MODE_W:          be_c = 4'b1111;
      default:         be_c = '0;
    endcase
    case (mem_acc_mode)
      MODE_B:  wdata_c = {4{wdata[7:0]}};
      MODE_H:  wdata_c = {2{wdata[15:0]}};
      default: wdata_c = wdata;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (launch) state_n = REQ;
      REQ:      if (dbus.req_ready) state_n = dbus.we ? DONE : WAIT_RSP;
      WAIT_RSP: if (dbus.rsp_valid) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign dbus.req_valid = (state == REQ);

  // Lane select uses the registered byte offset, not the live ALU address.
  always_comb begin
    lane     = dbus.rdata >> {off_q, 3'b000};
    load_ext = lane;
    case (mode_q)
      MODE_B:  load_ext = {{24{lane[7]}}, lane[7:0]};
      MODE_H:  load_ext = {{16{lane[15]}}, lane[15:0]};
      MODE_BU: load_ext = {24'd0, lane[7:0]};
      MODE_HU: load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdata      <= '0;
      dbus.we    <= 1'b0;
      dbus.addr  <= '0;
      dbus.be    <= '0;
      dbus.wdata <= '0;
      mode_q     <= '0;
      off_q      <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        dbus.we    <= wr_en;
        dbus.addr  <= {addr[31:2], 2'b00};
        dbus.be    <= be_c;
        dbus.wdata <= wdata_c;
        mode_q     <= mem_acc_mode;
        off_q      <= addr[1:0];
      end
      if ((state == WAIT_RSP) && dbus.rsp_valid)
        rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit: walks through loads, stores,
// misaligned and illegal requests, and reset during an access.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  mem_acc_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  lsu_if dbus ();

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .mem_acc_mode (mem_acc_mode),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misaligned   (misaligned),
    .dbus         (dbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    mem_acc_mode = 3'b111;
    addr = '0;
    wdata = '0;
    dbus.req_ready = 1'b0;
    dbus.rsp_valid = 1'b0;
    dbus.rdata = '0;

    // Reset values before any clock edge
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", {31'd0, dbus.req_valid}, 32'd0);
    chk("rst_we", {31'd0, dbus.we}, 32'd0);
    chk("rst_addr", dbus.addr, 32'h0);
    chk("rst_be", {28'd0, dbus.be}, 32'd0);
    chk("rst_wdata", dbus.wdata, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // LB 0x1003, ready at once, response next cycle
    rd_en = 1'b1; mem_acc_mode = 3'b000; addr = 32'h0000_1003; dbus.req_ready = 1'b1;
    #1;
    chk("lb_idle_stall", {31'd0, stall}, 32'd1);
    chk("lb_idle_valid", {31'd0, dbus.req_valid}, 32'd0);
    tick();
    chk("lb_req_valid", {31'd0, dbus.req_valid}, 32'd1);
    chk("lb_req_addr", dbus.addr, 32'h0000_1000);
    chk("lb_req_be", {28'd0, dbus.be}, 32'h8);
    chk("lb_req_we", {31'd0, dbus.we}, 32'd0);
    chk("lb_req_stall", {31'd0, stall}, 32'd1);
    tick();
    dbus.req_ready = 1'b0; dbus.rsp_valid = 1'b1; dbus.rdata = 32'h8000_0000;
    #1;
    chk("lb_wait_stall", {31'd0, stall}, 32'd1);
    chk("lb_wait_valid", {31'd0, dbus.req_valid}, 32'd0);
    tick();
    dbus.rsp_valid = 1'b0;
    #1;
    chk("lb_done_stall", {31'd0, stall}, 32'd0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    rd_en = 1'b0;
    tick();

    // SH 0x2002 with ready held low for 3 cycles; stray responses ignored
    wr_en = 1'b1; mem_acc_mode = 3'b001; addr = 32'h0000_2002; wdata = 32'h1234_ABCD;
    #1;
    chk("sh_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    dbus.rsp_valid = 1'b1; dbus.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dbus.req_ready = 1'b1;
      #1;
      chk("sh_req_valid", {31'd0, dbus.req_valid}, 32'd1);
      chk("sh_req_addr", dbus.addr, 32'h0000_2000);
      chk("sh_req_be", {28'd0, dbus.be}, 32'hC);
      chk("sh_req_wdata", dbus.wdata, 32'hABCD_ABCD);
      chk("sh_req_we", {31'd0, dbus.we}, 32'd1);
      chk("sh_req_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    dbus.req_ready = 1'b0; dbus.rsp_valid = 1'b0;
    #1;
    chk("sh_done_stall", {31'd0, stall}, 32'd0);
    chk("sh_done_valid", {31'd0, dbus.req_valid}, 32'd0);
    chk("sh_rdata_kept", rdata, 32'hFFFF_FF80);
    wr_en = 1'b0;
    tick();

    // LW misaligned
    rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h0000_3001; dbus.req_ready = 1'b1;
    #1;
    chk("lw_mis_flag", {31'd0, misaligned}, 32'd1);
    chk("lw_mis_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lw_mis_valid", {31'd0, dbus.req_valid}, 32'd0);
    chk("lw_mis_flag2", {31'd0, misaligned}, 32'd1);
    chk("lw_mis_rdata", rdata, 32'hFFFF_FF80);
    rd_en = 1'b0;
    #1;
    chk("lw_mis_clear", {31'd0, misaligned}, 32'd0);

    // Illegal modes: store with BU, load with 101
    wr_en = 1'b1; mem_acc_mode = 3'b011; addr = 32'h0000_0001;
    #1;
    chk("ill_st_stall", {31'd0, stall}, 32'd0);
    chk("ill_st_mis", {31'd0, misaligned}, 32'd0);
    tick();
    chk("ill_st_valid", {31'd0, dbus.req_valid}, 32'd0);
    wr_en = 1'b0; rd_en = 1'b1; mem_acc_mode = 3'b101;
    #1;
    chk("ill_ld_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("ill_ld_valid", {31'd0, dbus.req_valid}, 32'd0);
    chk("ill_ld_rdata", rdata, 32'hFFFF_FF80);

    // LHU 0x4002 then LH on the same word
    mem_acc_mode = 3'b100; addr = 32'h0000_4002;
    #1;
    chk("lhu_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lhu_req_be", {28'd0, dbus.be}, 32'hC);
    chk("lhu_req_addr", dbus.addr, 32'h0000_4000);
    tick();
    dbus.rsp_valid = 1'b1; dbus.rdata = 32'hF00D_1234;
    tick();
    dbus.rsp_valid = 1'b0;
    chk("lhu_rdata", rdata, 32'h0000_F00D);
    rd_en = 1'b0;
    tick();
    rd_en = 1'b1; mem_acc_mode = 3'b001;
    tick();
    chk("lh_req_valid", {31'd0, dbus.req_valid}, 32'd1);
    tick();
    dbus.rsp_valid = 1'b1;
    tick();
    dbus.rsp_valid = 1'b0;
    chk("lh_rdata", rdata, 32'hFFFF_F00D);
    rd_en = 1'b0;
    tick();

    // LW abandoned by reset in WAIT_RSP; late response ignored
    rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h0000_5000;
    tick();
    tick();
    rd_en = 1'b0; dbus.req_ready = 1'b0;
    #1;
    chk("lwr_wait_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("lwr_rst_rdata", rdata, 32'h0);
    chk("lwr_rst_addr", dbus.addr, 32'h0);
    chk("lwr_rst_be", {28'd0, dbus.be}, 32'd0);
    chk("lwr_rst_stall", {31'd0, stall}, 32'd0);
    chk("lwr_rst_valid", {31'd0, dbus.req_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    dbus.rsp_valid = 1'b1; dbus.rdata = 32'h1111_1111;
    tick();
    dbus.rsp_valid = 1'b0;
    chk("lwr_late_rdata", rdata, 32'h0);
    chk("lwr_late_stall", {31'd0, stall}, 32'd0);
    chk("lwr_late_valid", {31'd0, dbus.req_valid}, 32'd0);

    // SB, then rd_en&wr_en with W: store wins, no relaunch in DONE
    wr_en = 1'b1; mem_acc_mode = 3'b000; addr = 32'h0000_6001; wdata = 32'h0000_00A5;
    dbus.req_ready = 1'b1;
    #1;
    chk("sb_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("sb_req_be", {28'd0, dbus.be}, 32'h2);
    chk("sb_req_wdata", dbus.wdata, 32'hA5A5_A5A5);
    tick();
    chk("sb_done_stall", {31'd0, stall}, 32'd0);
    wr_en = 1'b0;
    tick();
    rd_en = 1'b1; wr_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h0000_6004; wdata = 32'hCAFE_F00D;
    tick();
    chk("rw_req_we", {31'd0, dbus.we}, 32'd1);
    chk("rw_req_be", {28'd0, dbus.be}, 32'hF);
    chk("rw_req_addr", dbus.addr, 32'h0000_6004);
    chk("rw_req_wdata", dbus.wdata, 32'hCAFE_F00D);
    tick();
    chk("rw_done_stall", {31'd0, stall}, 32'd0);
    chk("rw_done_valid", {31'd0, dbus.req_valid}, 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
    tick();
    chk("rw_idle_valid", {31'd0, dbus.req_valid}, 32'd0);
    chk("rw_rdata_kept", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
